// File: rtl/bam_seq_mul16_ctrl_if.sv
// rtl/bam_seq_mul16_ctrl_if.sv - request, shared-multiplier and result signals of the 16x16 sequencer
// master = requester/multiplier side, slave = controller side.
interface bam_seq_mul16_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_p;

   modport master (
      output in_valid, in_a, in_b, out_ready, mul_p,
      input  in_ready, mul_a, mul_b, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready, mul_p,
      output in_ready, mul_a, mul_b, out_valid, out_p
   );
endinterface

// File: rtl/bam_seq_mul16_ctrl.sv
// rtl/bam_seq_mul16_ctrl.sv - 16x16 unsigned multiply sequenced over one external 8x8 multiplier
// Optional macro MULSEQ_SKIP_LL_EN drops the LL partial product (truncated approximation).
module bam_seq_mul16_ctrl #(
   parameter int unsigned MUL_LAT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   bam_seq_mul16_ctrl_if.slave   bus,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

`ifdef MULSEQ_SKIP_LL_EN
   localparam logic [1:0] FIRST_PP = 2'd1;
`else
   localparam logic [1:0] FIRST_PP = 2'd0;
`endif
   localparam logic [1:0] LAT_INIT = 2'(MUL_LAT);

   state_t      state_q;
   logic [15:0] a_q, b_q;
   logic [31:0] acc_q;
   logic [1:0]  pp_q;
   logic [1:0]  cnt_q;
   logic [7:0]  mul_a_q, mul_b_q;
   logic        in_ready_q, out_valid_q, busy_q;
   logic [31:0] out_p_q;

   logic [31:0] pp_term;
   logic [31:0] acc_d;
   logic        capture;
   logic        last_pp;

   // pp index bit 1 selects the high byte of a, bit 0 the high byte of b
   function automatic logic [15:0] pp_ops(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] idx);
      logic [7:0] ma, mb;
      ma = idx[1] ? a[15:8] : a[7:0];
      mb = idx[0] ? b[15:8] : b[7:0];
      return {ma, mb};
   endfunction

   always_comb begin
      pp_term = {16'h0000, bus.mul_p};
      case (pp_q)
         2'd1, 2'd2: pp_term = {8'h00, bus.mul_p, 8'h00};
         2'd3:       pp_term = {bus.mul_p, 16'h0000};
         default:    pp_term = {16'h0000, bus.mul_p};
      endcase
   end

   assign acc_d   = acc_q + pp_term;
   assign last_pp = (pp_q == 2'd3);
   assign capture = ((state_q == S_ISSUE) && (MUL_LAT == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 2'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         pp_q        <= '0;
         cnt_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_p_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_q                <= bus.in_a;
                  b_q                <= bus.in_b;
                  acc_q              <= '0;
                  pp_q               <= FIRST_PP;
                  {mul_a_q, mul_b_q} <= pp_ops(bus.in_a, bus.in_b, FIRST_PP);
                  in_ready_q         <= 1'b0;
                  busy_q             <= 1'b1;
                  state_q            <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (MUL_LAT != 0) begin
                  cnt_q   <= LAT_INIT;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 2'd1;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // Capture overrides the per-state transition above.
         if (capture) begin
            acc_q <= acc_d;
            if (last_pp) begin
               out_p_q     <= acc_d;
               out_valid_q <= 1'b1;
               mul_a_q     <= '0;
               mul_b_q     <= '0;
               state_q     <= S_DONE;
            end else begin
               pp_q               <= pp_q + 2'd1;
               {mul_a_q, mul_b_q} <= pp_ops(a_q, b_q, pp_q + 2'd1);
               state_q            <= S_ISSUE;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_p     = out_p_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_bam_seq_mul16_ctrl.sv
// tb/tb_bam_seq_mul16_ctrl.sv - directed bench for the 16x16 sequencer at MUL_LAT 0 and 2
// Expected values for MULSEQ_SKIP_LL_EN builds come from the exp_skip column.
module tb_bam_seq_mul16_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic busy0, busy1;
   logic stub;
   logic [15:0] p1_q, p2_q;

   always #5 clk = ~clk;

   bam_seq_mul16_ctrl_if if0();
   bam_seq_mul16_ctrl_if if1();

   bam_seq_mul16_ctrl #(.MUL_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0), .busy(busy0));
   bam_seq_mul16_ctrl #(.MUL_LAT(2)) dut1 (.clk(clk), .rst(rst), .bus(if1), .busy(busy1));

   // Combinational multiplier (optionally a constant-1 stub) and a 2-stage pipelined one.
   assign if0.mul_p = stub ? 16'h0001 : ({8'h00, if0.mul_a} * {8'h00, if0.mul_b});
   always @(posedge clk) begin
      p1_q <= {8'h00, if1.mul_a} * {8'h00, if1.mul_b};
      p2_q <= p1_q;
   end
   assign if1.mul_p = p2_q;

`ifdef MULSEQ_SKIP_LL_EN
   localparam int NPP = 3;
   localparam int FIRST = 1;
`else
   localparam int NPP = 4;
   localparam int FIRST = 0;
`endif

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        stub;
      logic [31:0] exp_full;
      logic [31:0] exp_skip;
   } vec_t;

   vec_t vecs[8];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ops(input logic [15:0] a, input logic [15:0] b, input int idx);
      logic [7:0] ma, mb;
      ma = (idx >= 2) ? a[15:8] : a[7:0];
      mb = (idx % 2 == 1) ? b[15:8] : b[7:0];
      return {ma, mb};
   endfunction

   function automatic logic [31:0] pick(input vec_t v);
`ifdef MULSEQ_SKIP_LL_EN
      return v.exp_skip;
`else
      return v.exp_full;
`endif
   endfunction

   task automatic start0(input logic [15:0] a, input logic [15:0] b, input string name);
      @(negedge clk);
      if0.in_valid = 1'b1;
      if0.in_a = a;
      if0.in_b = b;
      chk({name, "_in_ready"}, {31'b0, if0.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if0.in_valid = 1'b0;
      if0.in_a = 16'hDEAD;
      if0.in_b = 16'hBEEF;
   endtask

   // Entered #1 after the accepting edge; leaves #1 after out_valid rose.
   task automatic wait0(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string name);
      int cycles = 0;
      for (int k = 0; k < 40; k++) begin
         if (if0.out_valid) break;
         if (k < NPP) begin
            chk($sformatf("%s_mul_k%0d", name, k), {16'h0, if0.mul_a, if0.mul_b},
                {16'h0, ops(a, b, FIRST + k)});
            chk($sformatf("%s_busy_k%0d", name, k), {31'b0, busy0}, 32'd1);
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      chk({name, "_latency"}, cycles, NPP);
      chk({name, "_out_p"}, if0.out_p, exp);
   endtask

   task automatic finish0(input string name);
      @(negedge clk);
      if0.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({name, "_valid_fall"}, {31'b0, if0.out_valid}, 32'd0);
      chk({name, "_ready_back"}, {31'b0, if0.in_ready}, 32'd1);
      chk({name, "_idle_busy"}, {31'b0, busy0}, 32'd0);
      if0.out_ready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060, 32'h0625E800};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 32'hFFFD0200};
      vecs[2] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F, 32'h00000000};
      vecs[3] = '{16'hA5C3, 16'h7E19, 1'b1, 32'h00010201, 32'h00010200};
      vecs[4] = '{16'h0100, 16'h0100, 1'b0, 32'h00010000, 32'h00010000};
      vecs[5] = '{16'h00FF, 16'hFF00, 1'b0, 32'h00FE0100, 32'h00FE0100};
      vecs[6] = '{16'h8000, 16'h0002, 1'b0, 32'h00010000, 32'h00010000};
      vecs[7] = '{16'h0000, 16'hABCD, 1'b0, 32'h00000000, 32'h00000000};

      rst = 1'b1;
      stub = 1'b0;
      if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.out_ready = 1'b0;
      if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", {31'b0, if0.in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, if0.out_valid}, 32'd0);
      chk("rst_out_p", if0.out_p, 32'd0);
      chk("rst_mul", {16'h0, if0.mul_a, if0.mul_b}, 32'd0);
      chk("rst_busy", {31'b0, busy0}, 32'd0);
      chk("rst_busy1", {31'b0, busy1}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         stub = vecs[i].stub;
         start0(vecs[i].a, vecs[i].b, $sformatf("v%0d", i));
         wait0(vecs[i].a, vecs[i].b, pick(vecs[i]), $sformatf("v%0d", i));
         finish0($sformatf("v%0d", i));
      end
      stub = 1'b0;

      // Backpressure in DONE with a competing request pending.
      start0(16'h1234, 16'h5678, "bp");
      wait0(16'h1234, 16'h5678, pick(vecs[0]), "bp");
      @(negedge clk);
      if0.in_valid = 1'b1;
      if0.in_a = 16'h0003;
      if0.in_b = 16'h0005;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold_valid_c%0d", c), {31'b0, if0.out_valid}, 32'd1);
         chk($sformatf("bp_hold_p_c%0d", c), if0.out_p, pick(vecs[0]));
         chk($sformatf("bp_hold_ready_c%0d", c), {31'b0, if0.in_ready}, 32'd0);
      end
      @(negedge clk);
      if0.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_xfer_valid", {31'b0, if0.out_valid}, 32'd0);
      chk("bp_xfer_ready", {31'b0, if0.in_ready}, 32'd1);
      chk("bp_xfer_p_kept", if0.out_p, pick(vecs[0]));
      @(negedge clk);
      if0.out_ready = 1'b0;
      @(posedge clk);
      #1;
      if0.in_valid = 1'b0;
      chk("bp_next_accept", {31'b0, if0.in_ready}, 32'd0);
      chk("bp_next_busy", {31'b0, busy0}, 32'd1);
      wait0(16'h0003, 16'h0005, pick(vecs[2]), "bp2");
      finish0("bp2");

      // Reset during the pp2 ISSUE cycle.
      start0(16'h1234, 16'h5678, "rs");
      repeat (2 - FIRST) @(posedge clk);
      #1;
      chk("rs_pp2_mul", {16'h0, if0.mul_a, if0.mul_b}, 32'h00001278);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rs_in_ready", {31'b0, if0.in_ready}, 32'd1);
      chk("rs_busy", {31'b0, busy0}, 32'd0);
      chk("rs_out_valid", {31'b0, if0.out_valid}, 32'd0);
      chk("rs_out_p", if0.out_p, 32'd0);
      chk("rs_mul", {16'h0, if0.mul_a, if0.mul_b}, 32'd0);
      start0(16'h0003, 16'h0005, "rs2");
      wait0(16'h0003, 16'h0005, pick(vecs[2]), "rs2");
      finish0("rs2");

      // MUL_LAT=2 instance: operands held 3 cycles per partial product.
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.in_a = 16'hFFFF;
      if1.in_b = 16'hFFFF;
      @(posedge clk);
      #1;
      if1.in_valid = 1'b0;
      if1.in_a = 16'h0000;
      if1.in_b = 16'h0000;
      begin
         int cycles = 0;
         for (int k = 0; k < 60; k++) begin
            if (if1.out_valid) break;
            if (k < 3 * NPP)
               chk($sformatf("l2_mul_k%0d", k), {16'h0, if1.mul_a, if1.mul_b},
                   {16'h0, ops(16'hFFFF, 16'hFFFF, FIRST + k / 3)});
            @(posedge clk);
            #1;
            cycles++;
         end
         chk("l2_latency", cycles, 3 * NPP);
      end
      chk("l2_out_p", if1.out_p, pick(vecs[1]));
      @(negedge clk);
      if1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("l2_valid_fall", {31'b0, if1.out_valid}, 32'd0);
      chk("l2_ready_back", {31'b0, if1.in_ready}, 32'd1);
      if1.out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
